// File: rtl/mpg_pkg.sv
// Shared types and limits for the multiphase clock/enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a. The WAIT state exists only when MPG_STEP_EN is defined.
package mpg_pkg;

  localparam int MPG_CFG_W_DFLT = 8;
  localparam int MPG_PHASES_MIN = 2;
  localparam int MPG_PHASES_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
`ifdef MPG_STEP_EN
    ST_GAP  = 2'd2,
    ST_WAIT = 2'd3
`else
    ST_GAP  = 2'd2
`endif
  } mpg_state_e;

endpackage

// File: rtl/mpg_dcount.sv
// Loadable down-counter with a zero flag; shared by the ON and GAP states.
// Latency: a load or decrement is visible one CLK after the request.
// Backpressure: none. It holds at zero instead of wrapping.
module mpg_dcount #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A load wins over a decrement. A decrement at zero is ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/multiphase_clkgen.sv
// N-phase non-overlapping one-hot phase generator with programmable high time and dead gap; optional single-step mode (MPG_STEP_EN).
// Latency: EN sampled at edge k -> PH[0] at edge k+1; all outputs are flops that trail the FSM by one cycle.
// Backpressure: EN is only sampled in IDLE and at rotation boundaries; with MPG_STEP_EN and SSTEP=1 each phase waits for STEP.
module multiphase_clkgen
  import mpg_pkg::*;
#(
  parameter int PHASES = 2,
  parameter int CFG_W  = MPG_CFG_W_DFLT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [CFG_W-1:0]  HIGH_CYC,
  input  logic [CFG_W-1:0]  GAP_CYC,
`ifdef MPG_STEP_EN
  input  logic              STEP,
  input  logic              SSTEP,
`endif
  output logic [PHASES-1:0] PH,
  output logic              O_S,
  output logic              BUSY
);

  localparam int IDX_W = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHASES - 1);

  if ((PHASES < MPG_PHASES_MIN) || (PHASES > MPG_PHASES_MAX)) begin : g_bad_phases
    $error("multiphase_clkgen: PHASES out of range");
  end

  mpg_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CFG_W-1:0]  h_q, h_d;
  logic [CFG_W-1:0]  g_q, g_d;
  logic              bnd_q, bnd_d;
  logic [PHASES-1:0] ph_q, ph_d;
  logic              os_q, os_d;
  logic              busy_q, busy_d;

  logic              cnt_ld;
  logic [CFG_W-1:0]  cnt_ld_val;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              phase_done;
  logic              go;
  logic [CFG_W-1:0]  hi_eff;

  // A zero high time behaves as one cycle.
  assign hi_eff = (HIGH_CYC == '0) ? CFG_W'(1) : HIGH_CYC;

  mpg_dcount #(.W(CFG_W)) u_cnt (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ld     (cnt_ld),
    .ld_val (cnt_ld_val),
    .dec    (cnt_dec),
    .zero   (cnt_zero)
  );

  // Next-state logic. The counter is reloaded with (length-1) on every state entry.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    h_d        = h_q;
    g_d        = g_q;
    bnd_d      = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    phase_done = 1'b0;
    go         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (EN) begin
          h_d        = hi_eff;
          g_d        = GAP_CYC;
          idx_d      = '0;
          state_d    = ST_ON;
          cnt_ld     = 1'b1;
          cnt_ld_val = hi_eff - CFG_W'(1);
        end
      end
      ST_ON: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (g_q != '0) begin
          state_d    = ST_GAP;
          cnt_ld     = 1'b1;
          cnt_ld_val = g_q - CFG_W'(1);
        end else begin
          phase_done = 1'b1;
        end
      end
      ST_GAP: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          phase_done = 1'b1;
        end
      end
`ifdef MPG_STEP_EN
      ST_WAIT: begin
        go = STEP || !SSTEP;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef MPG_STEP_EN
    // In single-step mode a finished phase parks in WAIT instead of advancing.
    if (phase_done) begin
      if (SSTEP) begin
        state_d = ST_WAIT;
      end else begin
        go = 1'b1;
      end
    end
`else
    go = phase_done;
`endif

    // Advance to the next phase, or close the rotation and re-sample EN.
    if (go) begin
      if (idx_q != LAST_IDX) begin
        idx_d      = idx_q + IDX_W'(1);
        state_d    = ST_ON;
        cnt_ld     = 1'b1;
        cnt_ld_val = h_q - CFG_W'(1);
      end else begin
        bnd_d = 1'b1;
        idx_d = '0;
        if (EN) begin
          h_d        = hi_eff;
          g_d        = GAP_CYC;
          state_d    = ST_ON;
          cnt_ld     = 1'b1;
          cnt_ld_val = hi_eff - CFG_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Output flops follow the current state, so the outputs trail the FSM by one cycle.
  always_comb begin
    ph_d   = (state_q == ST_ON) ? (PHASES'(1) << idx_q) : '0;
    busy_d = (state_q != ST_IDLE);
    os_d   = os_q ^ bnd_q;
  end

  // State and output registers; reset clears PH immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      h_q     <= '0;
      g_q     <= '0;
      bnd_q   <= 1'b0;
      ph_q    <= '0;
      os_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      h_q     <= h_d;
      g_q     <= g_d;
      bnd_q   <= bnd_d;
      ph_q    <= ph_d;
      os_q    <= os_d;
      busy_q  <= busy_d;
    end
  end

  assign PH   = ph_q;
  assign O_S  = os_q;
  assign BUSY = busy_q;

endmodule

// File: doc/multiphase_clkgen.md
# multiphase_clkgen

Parametrised N-phase non-overlapping clock/enable generator, successor to the fixed two-phase toggle generator. Drives PHASES one-hot phase outputs in strict rotation, each high for a programmable number of CLK cycles and separated by a programmable dead gap. It also provides a rotation-rate toggle output O_S. It sits between the system clock and the multi-phase datapath and latch enables.

## Interface
- PHASES, 2: number of phase outputs; legal range 2..8.
- CFG_W, 8: width of the HIGH_CYC and GAP_CYC configuration inputs.
- CLK  in  1  system clock; all state is updated on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  run request; sampled only in IDLE and at rotation boundaries.
- HIGH_CYC  in  CFG_W  high time of each phase in cycles; a value of 0 is treated as 1.
- GAP_CYC  in  CFG_W  dead cycles after each phase; 0 means phases run back-to-back.
- PH  out  PHASES  phase outputs; registered; one-hot or all-zero.
- O_S  out  1  toggles once per completed rotation.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- STEP, SSTEP  in  1 each  present only when MPG_STEP_EN is defined.

## Operation
- Reset values: PH=0, O_S=0, BUSY=0, state=IDLE, phase index=0, counters=0.
- The FSM has three states: IDLE, ON and GAP.
- IDLE:
  - PH=0.
  - When EN=1: latch H=max(HIGH_CYC,1) and G=GAP_CYC, set index=0, go to ON.
- ON:
  - PH[index]=1 and all other bits are 0.
  - The state lasts H cycles.
  - Then go to GAP if G>0; otherwise take the advance step directly.
- GAP:
  - PH=0.
  - The state lasts G cycles, then take the advance step.
- Advance step:
  - If index<PHASES-1: index+1, go to ON.
  - If index=PHASES-1, this is the rotation boundary:
    - toggle O_S and set index=0;
    - if EN=1, re-latch H and G from the current inputs and go to ON;
    - otherwise go to IDLE.
- HIGH_CYC and GAP_CYC changes between boundaries have no effect on the current rotation.
- EN deassertion mid-rotation is a graceful stop. The rotation completes and the FSM returns to IDLE at the boundary. A truncated phase is never produced.
- Invariant: at most one PH bit is high in any cycle, under all inputs.
- When G≥1, at least one all-zero cycle separates any two phase pulses.
- Async reset mid-pulse forces PH=0 immediately, without waiting for a CLK edge.
- After reset release, operation restarts from IDLE with index 0.
- Counters are CFG_W bits wide and count down. Reload values are H-1 and G-1, so no overflow is possible.

## Timing
- Start latency: EN is sampled high at edge k, and PH[0] rises at edge k+1.
- Rotation period: PHASES*(H+G) cycles.
- Example, PHASES=2, H=1, G=1: PH sequence 01,00,10,00 repeating, with a period of 4.
- O_S toggles on the same edge on which the final GAP ends, or on which the final ON ends when G=0. The O_S period is therefore 2*PHASES*(H+G).
- BUSY rises together with the first PH pulse. It falls on the edge that enters IDLE.
- All outputs are driven directly from flops; there is no combinational path from input to output.

## Configuration
- MPG_STEP_EN defined:
  - adds the STEP and SSTEP inputs;
  - while SSTEP=1, at the end of each GAP the FSM waits with PH=0 until a STEP pulse;
  - each STEP pulse (one cycle high) advances exactly one phase;
  - STEP while not waiting is ignored;
  - with G=0 and SSTEP=1, the wait is inserted after ON;
  - SSTEP=0 gives free-running behaviour.
- MPG_STEP_EN undefined: the STEP and SSTEP ports and the wait logic are absent, and the block is always free-running.

## Structure
- Shared package mpg_pkg holds:
  - the state enum (IDLE, ON, GAP, plus WAIT under MPG_STEP_EN);
  - the default CFG_W;
  - the PHASES range limits.
- Sub-module mpg_dcount: a loadable CFG_W down-counter with a zero flag. It is instantiated once and reloaded per state.

## Test plan
- Reset and start:
  - Stimulus: RST_N low, then high; PHASES=2, H=1, G=1, EN=1.
  - Required response: PH=00 during reset; then 01,00,10,00 repeating; O_S toggles every 4 cycles.
- Wide configuration:
  - Stimulus: PHASES=4, HIGH_CYC=3, GAP_CYC=2.
  - Required response: each PH bit high for 3 cycles, 2 zero cycles between phases, period 20, never more than one bit high.
- Back-to-back and zero high time:
  - Stimulus: PHASES=3, HIGH_CYC=0, GAP_CYC=0.
  - Required response: H=1, giving 001,010,100 with no gap and no overlap.
- Graceful stop and config isolation:
  - Stimulus: drop EN and change HIGH_CYC during phase 1.
  - Required response: the rotation finishes with the old H, BUSY falls at the boundary, PH stays 0 afterwards.
- Async reset mid-pulse:
  - Stimulus: RST_N low in the middle of an ON cycle.
  - Required response: PH=0 and O_S=0 without waiting for a CLK edge; the restart begins at PH[0].
- Single-step (MPG_STEP_EN):
  - Stimulus: SSTEP=1, three STEP pulses spaced 10 cycles apart.
  - Required response: exactly three phase pulses, PH=0 while waiting, extra STEP pulses during ON ignored.
